// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared constants and helpers for the UART transmit path.
//   - UART_FRAME_BITS : bits per frame (start + 8 data + stop)
//   - tx_state_t      : feeder FSM state encoding
//   - calc_bps_cnt    : sys_clk cycles per bit
//   - calc_frame_cyc  : sys_clk cycles per frame, including the idle guard
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } tx_state_t;

  function automatic int unsigned calc_bps_cnt(input int unsigned clk_fre,
                                               input int unsigned bps);
    return clk_fre / bps;
  endfunction

  function automatic int unsigned calc_frame_cyc(input int unsigned clk_fre,
                                                 input int unsigned bps,
                                                 input int unsigned guard_cyc);
    return UART_FRAME_BITS * calc_bps_cnt(clk_fre, bps) + guard_cyc;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered status flags.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write strobe and data; dropped when full unless popping
//   pop        : read strobe; caller guarantees !empty
//   dout       : current head entry (valid while !empty)
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
//   overflow   : one-cycle pulse when a push is dropped
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [AW:0]      count_d;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is read straight from storage so the consumer can register it on
  // the same edge that pops it.
  assign dout = mem[rd_ptr];

  always_comb begin
    count_d = count;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count + (AW+1)'(1);
      2'b01:   count_d = count - (AW+1)'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_d;
      full     <= (count_d == DEPTH_V);
      empty    <= (count_d == '0);
      overflow <= push && !push_ok;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//   Byte FIFO plus pacing controller in front of a UART transmitter that has
//   no ready output. One byte is presented per frame period with a clean
//   EN_HOLD-cycle enable pulse and data held stable for the whole frame.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   wr_en, wr_data     : push strobe and byte
//   full, empty        : FIFO status
//   fifo_cnt           : FIFO occupancy
//   overflow           : one-cycle pulse when a push is dropped
//   busy               : high from pop until the frame period ends
//   uart_tx_data       : byte presented to the transmitter
//   uart_tx_en         : transmit enable to the transmitter
// -----------------------------------------------------------------------------
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned BPS       = 115200,
  parameter int unsigned CLK_FRE   = 5000000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned EN_HOLD   = 4,
  parameter int unsigned GUARD_CYC = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     overflow,
  output logic                     busy,
  output logic [7:0]               uart_tx_data,
  output logic                     uart_tx_en
);

  localparam int unsigned FRAME_CYC = calc_frame_cyc(CLK_FRE, BPS, GUARD_CYC);
  localparam int unsigned CNT_W     = $clog2(FRAME_CYC);

  tx_state_t        state;
  tx_state_t        state_d;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_cnt_d;
  logic [7:0]       tx_data_d;
  logic             tx_en_d;
  logic             busy_d;
  logic             pop;
  logic [7:0]       head;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .push     (wr_en),
    .pop      (pop),
    .din      (wr_data),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_cnt),
    .overflow (overflow)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      uart_tx_data <= 8'h00;
      uart_tx_en   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      frame_cnt    <= frame_cnt_d;
      uart_tx_data <= tx_data_d;
      uart_tx_en   <= tx_en_d;
      busy         <= busy_d;
    end
  end

  // The frame counter starts at the pop edge, so the frame period (pop to
  // return to IDLE) is FRAME_CYC cycles; the enable register lags the state
  // by one edge, which places the rising edge two edges after the push.
  always_comb begin
    state_d     = state;
    frame_cnt_d = frame_cnt;
    tx_data_d   = uart_tx_data;
    tx_en_d     = 1'b0;
    busy_d      = busy;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (!empty) begin
          pop         = 1'b1;
          tx_data_d   = head;
          busy_d      = 1'b1;
          frame_cnt_d = '0;
          state_d     = START;
        end
      end
      START: begin
        tx_en_d     = 1'b1;
        frame_cnt_d = frame_cnt + CNT_W'(1);
        if (frame_cnt == CNT_W'(EN_HOLD - 1)) state_d = WAIT;
      end
      WAIT: begin
        frame_cnt_d = frame_cnt + CNT_W'(1);
        if (frame_cnt == CNT_W'(FRAME_CYC - 1)) begin
          frame_cnt_d = frame_cnt;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH     = 16;
  localparam int EN_HOLD   = 4;
  localparam int FRAME_CYC = 10 * (5000000 / 115200) + 4;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] fifo_cnt;
  logic       overflow;
  logic       busy;
  logic [7:0] uart_tx_data;
  logic       uart_tx_en;

  uart_tx_feeder #(
    .BPS       (115200),
    .CLK_FRE   (5000000),
    .DEPTH     (DEPTH),
    .EN_HOLD   (EN_HOLD),
    .GUARD_CYC (4)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .fifo_cnt     (fifo_cnt),
    .overflow     (overflow),
    .busy         (busy),
    .uart_tx_data (uart_tx_data),
    .uart_tx_en   (uart_tx_en)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: byte queue plus the time of the last pop.
  logic [7:0] m_q[$];
  logic [7:0] m_data   = 8'h00;
  bit         m_active = 1'b0;
  int         m_pop_t  = 0;
  bit         m_ovf    = 1'b0;

  int         rise_t[$];
  logic [7:0] rise_d[$];
  int         ovf_t[$];
  logic       prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge sys_clk) begin : cmp
    int   pre;
    bit   pop;
    bit   acc;
    int   d;
    logic exp_en;
    logic exp_busy;
    cyc++;
    if (!sys_rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_data   = 8'h00;
      m_ovf    = 1'b0;
    end else begin
      pre   = m_q.size();
      pop   = (pre > 0) && (!m_active || (cyc - m_pop_t) >= FRAME_CYC + 1);
      acc   = wr_en && (pre < DEPTH || pop);
      m_ovf = wr_en && !acc;
      if (pop) begin
        m_data   = m_q.pop_front();
        m_pop_t  = cyc;
        m_active = 1'b1;
      end
      if (acc) m_q.push_back(wr_data);
    end
    #1;
    d        = cyc - m_pop_t;
    exp_en   = m_active && d >= 1 && d <= EN_HOLD;
    exp_busy = m_active && d < FRAME_CYC;
    check("outputs{data,en,busy,ovf,full,empty,cnt}",
          {14'h0, uart_tx_data, uart_tx_en, busy, overflow, full, empty, fifo_cnt},
          {14'h0, m_data, exp_en, exp_busy, m_ovf, m_q.size() == DEPTH,
           m_q.size() == 0, 5'(m_q.size())});
    if (uart_tx_en && !prev_en) begin
      rise_t.push_back(cyc);
      rise_d.push_back(uart_tx_data);
    end
    prev_en = uart_tx_en;
    if (overflow) ovf_t.push_back(cyc);
  end

  // Pushes n bytes on consecutive edges; t0 is the edge index of the first.
  task automatic push_seq(input logic [7:0] start, input int n, input logic [7:0] step,
                          output int t0);
    t0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (i == 0) t0 = cyc + 1;
      wr_en   = 1'b1;
      wr_data = start + 8'(i) * step;
    end
    @(negedge sys_clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(empty && !busy && !uart_tx_en) && n < max) begin
      @(negedge sys_clk);
      n++;
    end
    check("idle_timeout", 32'(n < max), 32'd1);
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {14'h0, uart_tx_data, uart_tx_en, busy, overflow, full, empty, fifo_cnt},
          {14'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0});
  endtask

  initial begin
    int t0;
    int t1;
    int n;
    int rate;
    int rates[3] = '{3, 12, 70};
    sys_rst_n = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    repeat (3) @(negedge sys_clk);
    check_reset_vals("reset_state");
    sys_rst_n = 1'b1;

    check("bps_cnt_default",   calc_bps_cnt(5000000, 115200),      32'd43);
    check("frame_cyc_default", calc_frame_cyc(5000000, 115200, 4), 32'd434);
    check("bps_cnt_9600",      calc_bps_cnt(50000000, 9600),       32'd5208);
    check("frame_cyc_9600",    calc_frame_cyc(50000000, 9600, 4),  32'd52084);

    // Single byte
    rise_t.delete(); rise_d.delete();
    push_seq(8'h55, 1, 8'h00, t0);
    wait_idle(1000);
    check("t1_nrise", rise_t.size(), 1);
    if (rise_t.size() == 1) begin
      check("t1_rise_latency", rise_t[0] - t0, 2);
      check("t1_data", rise_d[0], 8'h55);
    end

    // Burst of three
    rise_t.delete(); rise_d.delete();
    push_seq(8'hA1, 3, 8'h11, t0);
    wait_idle(2000);
    check("t2_nrise", rise_t.size(), 3);
    if (rise_t.size() == 3) begin
      check("t2_rise0", rise_t[0] - t0, 2);
      check("t2_rise1", rise_t[1] - t0, 437);
      check("t2_rise2", rise_t[2] - t0, 872);
      check("t2_order", {rise_d[0], rise_d[1], rise_d[2]}, 24'hA1B2C3);
    end

    // Overfill: 18 pushes, last one dropped
    rise_t.delete(); rise_d.delete(); ovf_t.delete();
    push_seq(8'h00, 18, 8'h01, t0);
    wait_idle(9000);
    check("t3_novf", ovf_t.size(), 1);
    if (ovf_t.size() == 1) check("t3_ovf_at", ovf_t[0] - t0, 17);
    check("t3_nrise", rise_t.size(), 17);
    if (rise_t.size() == 17) begin
      check("t3_first", rise_d[0], 8'h00);
      check("t3_last", rise_d[16], 8'h10);
    end

    // Full FIFO with a push on the pop edge
    rise_t.delete(); rise_d.delete(); ovf_t.delete();
    push_seq(8'h80, 1, 8'h00, t0);
    push_seq(8'h90, 16, 8'h01, t1);
    @(negedge sys_clk);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    n = 0;
    while (rise_t.size() < 2 && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    wr_en = 1'b0;
    check("t4_timeout", 32'(n < 1000), 32'd1);
    wait_idle(9000);
    check("t4_novf", ovf_t.size(), 418);
    check("t4_nrise", rise_t.size(), 18);
    if (rise_t.size() == 18) begin
      check("t4_second", rise_d[1], 8'h90);
      check("t4_last", rise_d[17], 8'hEE);
    end

    // Reset during the second of four frames
    rise_t.delete(); rise_d.delete();
    push_seq(8'h31, 4, 8'h01, t0);
    n = 0;
    while (rise_t.size() < 2 && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    check("t5_timeout", 32'(n < 1000), 32'd1);
    repeat (50) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_reset_vals("t5_async_reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (1000) @(negedge sys_clk);
    check("t5_no_more_rise", rise_t.size(), 2);
    push_seq(8'h7A, 1, 8'h00, t1);
    wait_idle(1000);
    check("t5_nrise", rise_t.size(), 3);
    if (rise_t.size() == 3) begin
      check("t5_after_latency", rise_t[2] - t1, 2);
      check("t5_after_data", rise_d[2], 8'h7A);
    end

    // Random traffic at varying push rates
    for (int s = 0; s < 40; s++) begin
      rate = rates[$urandom_range(0, 2)];
      for (int c = 0; c < 500; c++) begin
        @(negedge sys_clk);
        wr_en   = ($urandom_range(0, 99) < rate);
        wr_data = 8'($urandom);
      end
    end
    @(negedge sys_clk);
    wr_en = 1'b0;
    wait_idle(20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
